resample_mpsched: RTL and testbench
===================================

RESAMPLE_MPSCHED -- requirements
Module: resample_mpsched

Interface
REQ-001 SHALL have parameter NSTAGE, default 3, number of resampler stages sharing one multiplier.
REQ-002 SHALL have parameter NCH, default 2, width of the pop trigger bus (one bit per channel).
REQ-003 SHALL have parameter SCHED_SLOT, default 40, cycles per multiplier slot; legal range 2..255.
REQ-004 SHALL have parameter CAND_W, default 24, multiplicand width.
REQ-005 SHALL have parameter PLIER_W, default 16, multiplier width.
REQ-006 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst  input  1  synchronous active-low reset.
REQ-008 SHALL have port pop_i  input  NCH  192k output pop; any nonzero value starts a schedule sequence.
REQ-009 SHALL have port stage_en_i  input  NSTAGE  per-stage enable mask, sampled only at sequence start.
REQ-010 SHALL have port mpcand_i  input  NSTAGE*CAND_W  packed multiplicands; stage k occupies bits [k*CAND_W +: CAND_W].
REQ-011 SHALL have port mplier_i  input  NSTAGE*PLIER_W  packed multipliers; stage k occupies bits [k*PLIER_W +: PLIER_W].
REQ-012 SHALL have port mpready_o  output  NSTAGE  one-hot slot grant to the stages.
REQ-013 SHALL have port mpcand_o  output  CAND_W  multiplicand to the shared multiplier.
REQ-014 SHALL have port mplier_o  output  PLIER_W  multiplier to the shared multiplier.
REQ-015 SHALL have port busy_o  output  1  high while a sequence is in progress.
REQ-016 SHALL have port overrun_cnt_o  output  8  saturating count of restarts that occurred while busy.

Function
REQ-017 SHALL implement the states IDLE and RUN; the state, slot counter, active-stage index and latched mask SHALL all be registers.
REQ-018 On a cycle where pop_i != 0, SHALL latch stage_en_i and enter RUN, granting the lowest-index enabled stage.
REQ-019 Pop seen at edge t SHALL give mpready_o valid from cycle t+1.
REQ-020 Stages SHALL be granted in ascending index order; disabled stages SHALL be skipped with no idle slot left in their place.
REQ-021 Each granted slot SHALL last exactly SCHED_SLOT cycles, with its mpready_o bit held high for the whole slot.
REQ-022 After SCHED_SLOT cycles, the grant SHALL move to the next enabled stage on the following cycle, with no gap cycle.
REQ-023 After the last enabled stage's slot, SHALL return to IDLE with mpready_o = 0 and busy_o = 0.
REQ-024 If the latched mask is all zero, SHALL stay in (or return to) IDLE, issue no grants and keep busy_o low.
REQ-025 mpready_o SHALL be zero or one-hot at all times.
REQ-026 busy_o SHALL equal (state == RUN).
REQ-027 mpcand_o and mplier_o SHALL be combinational selects (mux, not OR) of the granted stage's operand fields, and zero when no stage is granted.
REQ-028 A pop while busy_o = 1, including on the final cycle of the last slot, SHALL restart the sequence per REQ-018 and increment overrun_cnt_o.
REQ-029 overrun_cnt_o SHALL saturate at 255.
REQ-030 A pop in IDLE SHALL NOT increment overrun_cnt_o.
REQ-031 Changes on stage_en_i during RUN SHALL be ignored until the next sequence start.

Reset
REQ-032 While rst = 0 at a rising edge, SHALL force state IDLE, slot counter 0, latched mask 0, mpready_o 0, busy_o 0 and overrun_cnt_o 0; mpcand_o and mplier_o SHALL then read 0.
REQ-033 Reset SHALL take priority over a simultaneous pop.
REQ-034 Reset asserted mid-slot SHALL abort the sequence; no grant SHALL resume after release until a new pop.

Verification
REQ-035 Defaults, mask 3'b111, single pop -> mpready_o = 001 for 40 cycles, then 010 for 40, then 100 for 40; busy_o high for 120 cycles, then IDLE.
REQ-036 Mask 3'b101 -> 001 for 40 cycles, immediately followed by 100 for 40; busy_o high for 80 cycles total.
REQ-037 Second pop at cycle 50 of a full sequence -> grant returns to 001 next cycle, overrun_cnt_o = 1, full 120-cycle sequence follows.
REQ-038 Mask 0 with pop -> mpready_o and busy_o stay 0; mpcand_o = 0; overrun_cnt_o = 0.
REQ-039 mpcand_i stage fields 0x111111/0x222222/0x333333 -> mpcand_o tracks the granted stage exactly and is 0 in IDLE.
REQ-040 300 pops issued while busy -> overrun_cnt_o = 255; rst low for one cycle mid-slot -> all outputs 0 and idle until the next pop.

Source files
------------

// File: rtl/resample_mpsched.sv
// Time-slot scheduler that lends one shared multiplier to several resampler stages.
// A pop starts a sequence that grants each enabled stage SCHED_SLOT cycles, lowest index first.
module resample_mpsched #(
    parameter int NSTAGE     = 3,
    parameter int NCH        = 2,
    parameter int SCHED_SLOT = 40,
    parameter int CAND_W     = 24,
    parameter int PLIER_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NCH-1:0]              pop_i,
    input  logic [NSTAGE-1:0]           stage_en_i,
    input  logic [NSTAGE*CAND_W-1:0]    mpcand_i,
    input  logic [NSTAGE*PLIER_W-1:0]   mplier_i,
    output logic [NSTAGE-1:0]           mpready_o,
    output logic [CAND_W-1:0]           mpcand_o,
    output logic [PLIER_W-1:0]          mplier_o,
    output logic                        busy_o,
    output logic [7:0]                  overrun_cnt_o
);

    localparam int IDXW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
    localparam logic [7:0] SLOT_LAST = 8'(SCHED_SLOT - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t            state;
    logic [7:0]        slot_cnt;
    logic [IDXW-1:0]   active_idx;
    logic [NSTAGE-1:0] mask_q;
    logic [NSTAGE-1:0] mpready_q;
    logic [7:0]        overrun_cnt;

    logic [IDXW-1:0]   first_idx;
    logic [NSTAGE-1:0] first_oh;
    logic              first_found;
    logic [IDXW-1:0]   next_idx;
    logic [NSTAGE-1:0] next_oh;
    logic              next_found;

    // Descending scans so the last hit wins: lowest enabled stage, and the lowest one above the active stage.
    always_comb begin
        first_idx   = '0;
        first_oh    = '0;
        first_found = 1'b0;
        next_idx    = '0;
        next_oh     = '0;
        next_found  = 1'b0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (stage_en_i[i]) begin
                first_idx   = IDXW'(i);
                first_oh    = '0;
                first_oh[i] = 1'b1;
                first_found = 1'b1;
            end
            if (mask_q[i] && (IDXW'(i) > active_idx)) begin
                next_idx   = IDXW'(i);
                next_oh    = '0;
                next_oh[i] = 1'b1;
                next_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            slot_cnt    <= '0;
            active_idx  <= '0;
            mask_q      <= '0;
            mpready_q   <= '0;
            overrun_cnt <= '0;
        end else if (pop_i != '0) begin
            mask_q   <= stage_en_i;
            slot_cnt <= '0;
            if ((state == RUN) && (overrun_cnt != 8'hFF)) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
            if (first_found) begin
                state      <= RUN;
                active_idx <= first_idx;
                mpready_q  <= first_oh;
            end else begin
                state      <= IDLE;
                active_idx <= '0;
                mpready_q  <= '0;
            end
        end else if (state == RUN) begin
            if (slot_cnt == SLOT_LAST) begin
                slot_cnt <= '0;
                if (next_found) begin
                    active_idx <= next_idx;
                    mpready_q  <= next_oh;
                end else begin
                    state      <= IDLE;
                    active_idx <= '0;
                    mpready_q  <= '0;
                end
            end else begin
                slot_cnt <= slot_cnt + 8'd1;
            end
        end
    end

    // Index-driven mux so the operands come from exactly one stage, forced to zero while idle.
    always_comb begin
        mpcand_o = '0;
        mplier_o = '0;
        if (state == RUN) begin
            for (int k = 0; k < NSTAGE; k++) begin
                if (active_idx == IDXW'(k)) begin
                    mpcand_o = mpcand_i[k*CAND_W +: CAND_W];
                    mplier_o = mplier_i[k*PLIER_W +: PLIER_W];
                end
            end
        end
    end

    assign mpready_o     = mpready_q;
    assign busy_o        = (state == RUN);
    assign overrun_cnt_o = overrun_cnt;

endmodule

// File: tb/tb_resample_mpsched.sv
// Bench for resample_mpsched: a queue-based schedule model checked every cycle,
// plus directed scenarios with hand-computed slot timing and counter values.
module tb_resample_mpsched;

    localparam int NSTAGE     = 3;
    localparam int NCH        = 2;
    localparam int SCHED_SLOT = 40;
    localparam int CAND_W     = 24;
    localparam int PLIER_W    = 16;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NCH-1:0]             pop_i;
    logic [NSTAGE-1:0]          stage_en_i;
    logic [NSTAGE*CAND_W-1:0]   mpcand_i;
    logic [NSTAGE*PLIER_W-1:0]  mplier_i;
    logic [NSTAGE-1:0]          mpready_o;
    logic [CAND_W-1:0]          mpcand_o;
    logic [PLIER_W-1:0]         mplier_o;
    logic                       busy_o;
    logic [7:0]                 overrun_cnt_o;

    logic [CAND_W-1:0]  cand_f  [NSTAGE];
    logic [PLIER_W-1:0] plier_f [NSTAGE];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int seq[$];
    int pos = 0;
    int exp_ovr = 0;

    int rdy_log  [256];
    int cand_log [256];
    int busy_cnt;

    resample_mpsched #(
        .NSTAGE(NSTAGE), .NCH(NCH), .SCHED_SLOT(SCHED_SLOT),
        .CAND_W(CAND_W), .PLIER_W(PLIER_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pop_i(pop_i),
        .stage_en_i(stage_en_i),
        .mpcand_i(mpcand_i),
        .mplier_i(mplier_i),
        .mpready_o(mpready_o),
        .mpcand_o(mpcand_o),
        .mplier_o(mplier_o),
        .busy_o(busy_o),
        .overrun_cnt_o(overrun_cnt_o)
    );

    always #5 clk = ~clk;

    always_comb begin
        mpcand_i = '0;
        mplier_i = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            mpcand_i[k*CAND_W +: CAND_W]   = cand_f[k];
            mplier_i[k*PLIER_W +: PLIER_W] = plier_f[k];
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_stimulus(input logic [NCH-1:0] pop, input logic [NSTAGE-1:0] en);
        pop_i      = pop;
        stage_en_i = en;
        tick();
        pop_i = '0;
    endtask

    // Records the grant and operand seen on every busy cycle until the sequence ends.
    task automatic measure_sequence(output int n);
        n = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (!busy_o) break;
            rdy_log[i]  = int'(mpready_o);
            cand_log[i] = int'(mpcand_o);
            n++;
        end
        if (n >= 256) check_output("sequence_timeout", 32'(n), 32'd0);
    endtask

    // Schedule model: a sequence is the list of enabled stages, each owning SCHED_SLOT cycles.
    always @(posedge clk) begin
        if (!rst) begin
            seq.delete();
            pos     = 0;
            exp_ovr = 0;
        end else if (pop_i != '0) begin
            if (seq.size() > 0 && exp_ovr < 255) exp_ovr++;
            seq.delete();
            for (int s = 0; s < NSTAGE; s++) begin
                if (stage_en_i[s]) seq.push_back(s);
            end
            pos = 0;
        end else if (seq.size() > 0) begin
            pos++;
            if (pos >= seq.size() * SCHED_SLOT) begin
                seq.delete();
                pos = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] exp_rdy;
            logic [31:0] exp_cand;
            logic [31:0] exp_plier;
            logic [31:0] exp_busy;
            exp_rdy   = '0;
            exp_cand  = '0;
            exp_plier = '0;
            exp_busy  = '0;
            if (seq.size() > 0) begin
                int st;
                st        = seq[pos / SCHED_SLOT];
                exp_rdy   = 32'(1) << st;
                exp_cand  = 32'(cand_f[st]);
                exp_plier = 32'(plier_f[st]);
                exp_busy  = 32'd1;
            end
            check_output("model_mpready", 32'(mpready_o), exp_rdy);
            check_output("model_busy", 32'(busy_o), exp_busy);
            check_output("model_mpcand", 32'(mpcand_o), exp_cand);
            check_output("model_mplier", 32'(mplier_o), exp_plier);
            check_output("model_overrun", 32'(overrun_cnt_o), 32'(exp_ovr));
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b0;
        pop_i      = '0;
        stage_en_i = '0;
        cand_f[0]  = 24'h111111;
        cand_f[1]  = 24'h222222;
        cand_f[2]  = 24'h333333;
        plier_f[0] = 16'h1111;
        plier_f[1] = 16'h2222;
        plier_f[2] = 16'h3333;
        tick();
        tick();
        chk_en = 1'b1;
        @(negedge clk);
        check_output("reset_mpready", 32'(mpready_o), 32'd0);
        check_output("reset_busy", 32'(busy_o), 32'd0);
        check_output("reset_overrun", 32'(overrun_cnt_o), 32'd0);
        check_output("reset_mpcand", 32'(mpcand_o), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Empty mask: pop must not start anything or count as an overrun.
        apply_stimulus(2'b01, 3'b000);
        @(negedge clk);
        check_output("mask0_busy", 32'(busy_o), 32'd0);
        check_output("mask0_mpready", 32'(mpready_o), 32'd0);
        check_output("mask0_mpcand", 32'(mpcand_o), 32'd0);
        check_output("mask0_overrun", 32'(overrun_cnt_o), 32'd0);
        tick();

        // Full mask: 001, 010, 100 for 40 cycles each.
        apply_stimulus(2'b01, 3'b111);
        measure_sequence(busy_cnt);
        check_output("full_busy_cycles", 32'(busy_cnt), 32'd120);
        check_output("full_grant_first", 32'(rdy_log[0]), 32'h1);
        check_output("full_grant_39", 32'(rdy_log[39]), 32'h1);
        check_output("full_grant_40", 32'(rdy_log[40]), 32'h2);
        check_output("full_grant_80", 32'(rdy_log[80]), 32'h4);
        check_output("full_grant_119", 32'(rdy_log[119]), 32'h4);
        check_output("full_cand_s0", 32'(cand_log[0]), 32'h111111);
        check_output("full_cand_s1", 32'(cand_log[45]), 32'h222222);
        check_output("full_cand_s2", 32'(cand_log[100]), 32'h333333);
        check_output("full_idle_mpcand", 32'(mpcand_o), 32'd0);
        check_output("full_idle_mpready", 32'(mpready_o), 32'd0);
        check_output("full_idle_overrun", 32'(overrun_cnt_o), 32'd0);
        tick();

        // Mask 101: stage 1 skipped with no gap.
        apply_stimulus(2'b01, 3'b101);
        measure_sequence(busy_cnt);
        check_output("skip_busy_cycles", 32'(busy_cnt), 32'd80);
        check_output("skip_grant_39", 32'(rdy_log[39]), 32'h1);
        check_output("skip_grant_40", 32'(rdy_log[40]), 32'h4);
        check_output("skip_grant_79", 32'(rdy_log[79]), 32'h4);
        tick();

        // Restart in the middle of the second slot.
        apply_stimulus(2'b01, 3'b111);
        repeat (49) tick();
        apply_stimulus(2'b10, 3'b111);
        measure_sequence(busy_cnt);
        check_output("restart_busy_cycles", 32'(busy_cnt), 32'd120);
        check_output("restart_grant_first", 32'(rdy_log[0]), 32'h1);
        check_output("restart_overrun", 32'(overrun_cnt_o), 32'd1);
        tick();

        // Pop on the final cycle of the last slot still counts as an overrun.
        apply_stimulus(2'b01, 3'b001);
        repeat (39) tick();
        apply_stimulus(2'b01, 3'b001);
        @(negedge clk);
        check_output("lastcycle_overrun", 32'(overrun_cnt_o), 32'd2);
        check_output("lastcycle_mpready", 32'(mpready_o), 32'h1);
        measure_sequence(busy_cnt);
        check_output("lastcycle_busy_cycles", 32'(busy_cnt), 32'd39);
        tick();

        // Mask changes during a sequence are ignored.
        apply_stimulus(2'b01, 3'b001);
        stage_en_i = 3'b111;
        measure_sequence(busy_cnt);
        check_output("maskchange_busy_cycles", 32'(busy_cnt), 32'd40);
        tick();

        // Continuous pops: 1 from idle plus 300 while busy saturates the counter.
        stage_en_i = 3'b111;
        pop_i      = 2'b01;
        repeat (301) tick();
        pop_i = '0;
        @(negedge clk);
        check_output("saturate_overrun", 32'(overrun_cnt_o), 32'd255);
        repeat (10) tick();

        // Reset mid-slot, coinciding with a pop, wins and leaves the block idle.
        rst   = 1'b0;
        pop_i = 2'b01;
        tick();
        pop_i = '0;
        @(negedge clk);
        check_output("midreset_busy", 32'(busy_o), 32'd0);
        check_output("midreset_mpready", 32'(mpready_o), 32'd0);
        check_output("midreset_overrun", 32'(overrun_cnt_o), 32'd0);
        check_output("midreset_mpcand", 32'(mpcand_o), 32'd0);
        check_output("midreset_mplier", 32'(mplier_o), 32'd0);
        tick();
        rst = 1'b1;
        repeat (50) tick();
        @(negedge clk);
        check_output("postreset_busy", 32'(busy_o), 32'd0);
        check_output("postreset_mpready", 32'(mpready_o), 32'd0);
        tick();

        apply_stimulus(2'b01, 3'b010);
        @(negedge clk);
        check_output("newpop_mpready", 32'(mpready_o), 32'h2);
        check_output("newpop_mplier", 32'(mplier_o), 32'h2222);
        measure_sequence(busy_cnt);
        check_output("newpop_busy_cycles", 32'(busy_cnt), 32'd39);
        tick();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
